ball: RTL and testbench

Ball motion engine for the Pong playfield: the stage directly downstream of the player paddle. It consumes the paddle's bounding-box edges and moves a square ball one step per animation strobe. It bounces the ball off the left, right and top walls and off the paddle's top face, and flags a miss when the ball reaches the bottom edge. Outputs are ball bounding-box edges for the pixel renderer, plus a rally hit count and a miss pulse for the score logic.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/box_overlap.sv | 16 +
 rtl/ball.sv | 156 +++++++++++++++
 tb/tb_ball.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong playfield definitions: coordinate width, default display size,
// ball state encoding and the bounding-box payload used by overlap checks.
package pong_pkg;

  localparam int unsigned COORD_W  = 12;
  localparam int unsigned D_WIDTH  = 640;
  localparam int unsigned D_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } state_t;

  // Axis-aligned box given by its left, right, top and bottom edges.
  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test between two boxes; edges are inclusive, so boxes
// that merely touch count as overlapping.
//   a, b       : boxes to compare
//   overlap_c  : 1 when the boxes share at least one pixel
module box_overlap
  import pong_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic overlap_c
);

  assign overlap_c = (a.y2 >= b.y1) && (a.y1 <= b.y2) &&
                     (a.x2 >= b.x1) && (a.x1 <= b.x2);

endmodule

// File: rtl/ball.sv
// Ball motion engine: serves the ball, moves it one step per animation tick,
// bounces it off the side/top walls and the paddle top face, and flags a miss
// at the bottom edge.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_ani_stb, i_animate         : frame strobe and run enable (tick = both)
//   i_pad_x1/x2/y1/y2            : paddle box edges
//   o_x1/x2/y1/y2                : ball box edges (combinational from centre)
//   o_state, o_hits, o_miss      : state, rally hit count, one-cycle miss pulse
module ball
  import pong_pkg::*;
#(
  parameter int unsigned H_SIZE       = 8,
  parameter int unsigned IX           = 320,
  parameter int unsigned IY           = 120,
  parameter int unsigned D_WIDTH      = pong_pkg::D_WIDTH,
  parameter int unsigned D_HEIGHT     = pong_pkg::D_HEIGHT,
  parameter int unsigned STEP         = 2,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic [COORD_W-1:0] i_pad_x1,
  input  logic [COORD_W-1:0] i_pad_x2,
  input  logic [COORD_W-1:0] i_pad_y1,
  input  logic [COORD_W-1:0] i_pad_y2,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_x2,
  output logic [COORD_W-1:0] o_y1,
  output logic [COORD_W-1:0] o_y2,
  output logic [1:0]         o_state,
  output logic [7:0]         o_hits,
  output logic               o_miss
);

  localparam int unsigned CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

  localparam logic [COORD_W-1:0] C_H      = COORD_W'(H_SIZE);
  localparam logic [COORD_W-1:0] C_STEP   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] C_IX     = COORD_W'(IX);
  localparam logic [COORD_W-1:0] C_IY     = COORD_W'(IY);
  localparam logic [COORD_W-1:0] C_RIGHT  = COORD_W'(D_WIDTH - 1 - STEP);
  localparam logic [COORD_W-1:0] C_BOTTOM = COORD_W'(D_HEIGHT - 1);
  localparam logic [CNT_W-1:0]   C_SERVE  = CNT_W'(SERVE_FRAMES);

  logic [COORD_W-1:0] x, y;
  logic               dx, dy;
  logic [CNT_W-1:0]   cnt;
  state_t             state;
  logic [7:0]         hits;
  logic               miss;

  logic               tick;
  logic               pad_ovl_c;
  logic               hit_c, miss_c, dx_n, dy_n;
  logic [COORD_W-1:0] x_mv, y_mv;
  logic [CNT_W-1:0]   cnt_inc;
  box_t               ball_box, pad_box;

  assign o_x1    = x - C_H;
  assign o_x2    = x + C_H;
  assign o_y1    = y - C_H;
  assign o_y2    = y + C_H;
  assign o_state = state;
  assign o_hits  = hits;
  assign o_miss  = miss;

  assign tick = i_ani_stb & i_animate;

  assign ball_box = '{x1: o_x1, x2: o_x2, y1: o_y1, y2: o_y2};
  assign pad_box  = '{x1: i_pad_x1, x2: i_pad_x2, y1: i_pad_y1, y2: i_pad_y2};

  box_overlap u_pad_hit (
    .a         (ball_box),
    .b         (pad_box),
    .overlap_c (pad_ovl_c)
  );

  // Bounce/miss decisions on the current registered position.
  always_comb begin
    dx_n    = dx;
    dy_n    = dy;
    cnt_inc = cnt + CNT_W'(1);
    // Only a descending ball can hit the paddle, so it cannot re-trigger
    // while still overlapping after the bounce.
    hit_c   = dy & pad_ovl_c;
    miss_c  = dy & ~hit_c & (o_y2 >= C_BOTTOM);
    if (o_x1 <= C_STEP) begin
      dx_n = 1'b1;
    end else if (o_x2 >= C_RIGHT) begin
      dx_n = 1'b0;
    end
    if (o_y1 <= C_STEP) begin
      dy_n = 1'b1;
    end
    if (hit_c) begin
      dy_n = 1'b0;
    end
    x_mv = dx_n ? (x + C_STEP) : (x - C_STEP);
    y_mv = dy_n ? (y + C_STEP) : (y - C_STEP);
  end

  // State, position and scoring registers; everything advances only on a tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x     <= C_IX;
      y     <= C_IY;
      dx    <= 1'b1;
      dy    <= 1'b1;
      cnt   <= '0;
      state <= ST_SERVE;
      hits  <= '0;
      miss  <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (tick) begin
        case (state)
          ST_SERVE: begin
            if (cnt_inc == C_SERVE) begin
              state <= ST_PLAY;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_PLAY: begin
            if (miss_c) begin
              state <= ST_MISS;
              miss  <= 1'b1;
            end else begin
              dx <= dx_n;
              dy <= dy_n;
              x  <= x_mv;
              y  <= y_mv;
              if (hit_c && (hits != 8'hFF)) begin
                hits <= hits + 8'd1;
              end
            end
          end
          ST_MISS: begin
            state <= ST_SERVE;
            x     <= C_IX;
            y     <= C_IY;
            dx    <= 1'b1;
            dy    <= 1'b1;
            hits  <= '0;
            cnt   <= '0;
          end
          default: state <= ST_SERVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball.sv
// Scoreboard bench for ball: stimulus pushes hand-computed expectations, a
// monitor pops and compares them one clock edge later.
module tb_ball;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ani_stb, i_animate;
  logic [11:0] i_pad_x1, i_pad_x2, i_pad_y1, i_pad_y2;

  logic [11:0] a_x1, a_x2, a_y1, a_y2, b_x1, b_x2, b_y1, b_y2;
  logic [1:0]  a_st, b_st;
  logic [7:0]  a_hits, b_hits;
  logic        a_miss, b_miss;

  always #5 i_clk = ~i_clk;

  ball #(.SERVE_FRAMES(4)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_pad_x1(i_pad_x1), .i_pad_x2(i_pad_x2), .i_pad_y1(i_pad_y1), .i_pad_y2(i_pad_y2),
    .o_x1(a_x1), .o_x2(a_x2), .o_y1(a_y1), .o_y2(a_y2),
    .o_state(a_st), .o_hits(a_hits), .o_miss(a_miss)
  );

  ball #(.IX(630), .SERVE_FRAMES(4)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_pad_x1(i_pad_x1), .i_pad_x2(i_pad_x2), .i_pad_y1(i_pad_y1), .i_pad_y2(i_pad_y2),
    .o_x1(b_x1), .o_x2(b_x2), .o_y1(b_y1), .o_y2(b_y2),
    .o_state(b_st), .o_hits(b_hits), .o_miss(b_miss)
  );

  typedef struct {
    bit    sel;
    string name;
    int    x1, y1, st, hits, miss;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic compare(input exp_t e);
    int ax1, ax2, ay1, ay2, ast, ahits, amiss;
    ax1   = e.sel ? int'(b_x1)   : int'(a_x1);
    ax2   = e.sel ? int'(b_x2)   : int'(a_x2);
    ay1   = e.sel ? int'(b_y1)   : int'(a_y1);
    ay2   = e.sel ? int'(b_y2)   : int'(a_y2);
    ast   = e.sel ? int'(b_st)   : int'(a_st);
    ahits = e.sel ? int'(b_hits) : int'(a_hits);
    amiss = e.sel ? int'(b_miss) : int'(a_miss);
    n_tests++;
    if (ax1 != e.x1 || ax2 != e.x1 + 16 || ay1 != e.y1 || ay2 != e.y1 + 16 ||
        ast != e.st || ahits != e.hits || amiss != e.miss) begin
      n_fail++;
      $display("FAIL %s: got x1=%0d x2=%0d y1=%0d y2=%0d st=%0d hits=%0d miss=%0d; want x1=%0d x2=%0d y1=%0d y2=%0d st=%0d hits=%0d miss=%0d",
               e.name, ax1, ax2, ay1, ay2, ast, ahits, amiss,
               e.x1, e.x1 + 16, e.y1, e.y1 + 16, e.st, e.hits, e.miss);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      while (q.size() > 0) compare(q.pop_front());
    end
  end

  task automatic drive(input bit stb, input bit anim, input bit rst);
    @(negedge i_clk);
    i_ani_stb = stb;
    i_animate = anim;
    i_rst     = rst;
  endtask

  task automatic chk(input bit sel, input string nm, input int x1, input int y1,
                     input int st, input int hits, input int miss);
    exp_t e;
    e.sel = sel; e.name = nm; e.x1 = x1; e.y1 = y1;
    e.st = st; e.hits = hits; e.miss = miss;
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge i_clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      drive(1'b1, 1'b1, 1'b0);
      settle();
    end
  endtask

  task automatic tick_chk(input bit sel, input string nm, input int x1, input int y1,
                          input int st, input int hits, input int miss);
    drive(1'b1, 1'b1, 1'b0);
    chk(sel, nm, x1, y1, st, hits, miss);
    settle();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1);
    chk(1'b0, "rst_a", 312, 112, 0, 0, 0);
    chk(1'b1, "rst_b", 622, 112, 0, 0, 0);
    settle();
  endtask

  task automatic set_pad(input int x1, input int x2, input int y1, input int y2);
    i_pad_x1 = 12'(x1);
    i_pad_x2 = 12'(x2);
    i_pad_y1 = 12'(y1);
    i_pad_y2 = 12'(y2);
  endtask

  initial begin
    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b0;
    set_pad(0, 0, 0, 0);

    // Serve countdown, with a non-animating strobe in the middle.
    do_reset();
    tick_chk(1'b0, "serve_t1", 312, 112, 0, 0, 0);
    tick_chk(1'b0, "serve_t2", 312, 112, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    chk(1'b0, "serve_noanim", 312, 112, 0, 0, 0);
    settle();
    tick_chk(1'b0, "serve_t3", 312, 112, 0, 0, 0);
    tick_chk(1'b0, "serve_t4", 312, 112, 1, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    chk(1'b0, "play_noanim", 312, 112, 1, 0, 0);
    settle();
    tick_chk(1'b0, "play_t1", 314, 114, 1, 0, 0);

    // Right wall bounce on the first play tick (serve x=630).
    do_reset();
    ticks(4);
    tick_chk(1'b1, "rwall_t1", 620, 114, 1, 0, 0);
    tick_chk(1'b1, "rwall_t2", 618, 116, 1, 0, 0);
    tick_chk(1'b1, "rwall_t3", 616, 118, 1, 0, 0);

    // Paddle hit at y=192, no re-trigger afterwards.
    set_pad(240, 400, 200, 216);
    do_reset();
    ticks(4);
    ticks(35);
    tick_chk(1'b0, "pad_pre",    384, 184, 1, 0, 0);
    tick_chk(1'b0, "pad_hit",    386, 182, 1, 1, 0);
    tick_chk(1'b0, "pad_after",  388, 180, 1, 1, 0);
    tick_chk(1'b0, "pad_after2", 390, 178, 1, 1, 0);

    // Miss at the bottom edge after a right-wall bounce.
    set_pad(0, 100, 300, 316);
    do_reset();
    ticks(4);
    ticks(155);
    tick_chk(1'b0, "miss_rwall", 620, 424, 1, 0, 0);
    ticks(19);
    tick_chk(1'b0, "miss_pre", 580, 464, 1, 0, 0);
    tick_chk(1'b0, "miss_det", 580, 464, 2, 0, 1);
    drive(1'b0, 1'b0, 1'b0);
    chk(1'b0, "miss_clr", 580, 464, 2, 0, 0);
    settle();
    drive(1'b1, 1'b0, 1'b0);
    chk(1'b0, "miss_frozen", 580, 464, 2, 0, 0);
    settle();
    tick_chk(1'b0, "reserve", 312, 112, 0, 0, 0);

    // Long rally against a full-width paddle, then reset during a tick.
    set_pad(0, 639, 200, 216);
    do_reset();
    ticks(4);
    ticks(36);
    tick_chk(1'b0, "rally_h1", 386, 182, 1, 1, 0);
    ticks(90);
    tick_chk(1'b0, "rally_top", 568, 4, 1, 1, 0);
    ticks(90);
    tick_chk(1'b0, "rally_h2", 494, 182, 1, 2, 0);
    ticks(181);
    tick_chk(1'b0, "rally_h3", 130, 182, 1, 3, 0);
    drive(1'b1, 1'b1, 1'b1);
    chk(1'b0, "rst_mid", 312, 112, 0, 0, 0);
    settle();

    drive(1'b0, 1'b0, 1'b0);
    settle();
    @(negedge i_clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
